// File: rtl/axi_bridge.sv
// axi_bridge
// ----------
// Bridges the core's two SRAM-like ports onto one AXI3 master port.
// The instruction port is read-only. The data port carries both loads and
// stores. Fetches and loads share AR/R, with a data load winning over a fetch
// in the same cycle. Stores use AW/W/B.
//
// The data port is serialised: at most one data transaction (load or store)
// is outstanding at a time. A fetch may run alongside an outstanding store.
//
// Ports
//   clk, reset              : clock and synchronous active-high reset
//   inst_sram_*             : instruction request/response port (read-only)
//   data_sram_*             : data request/response port (load/store)
//   ar* / r*                : AXI3 read address and read data channels
//   aw* / w* / b*           : AXI3 write address, write data and response
//   unused AXI inputs       : rresp, rlast, bid, bresp (ignored)
module axi_bridge (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_B    = 2'd2
  } wr_state_e;

  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;

  logic [3:0]  arid_q,   arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;

  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  wstrb_q,  wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;

  logic        data_busy_s;
  logic        load_acc_s;
  logic        store_acc_s;
  logic        fetch_acc_s;
  logic        unused_inputs_s;

  // Acceptance decode: the data port is serialised against any outstanding
  // data read (arid 1) or store; a fetch yields to a load in the same cycle.
  always_comb begin
    data_busy_s = ((rd_state_q != RD_IDLE) && (arid_q == 4'd1)) ||
                  (wr_state_q != WR_IDLE);
    load_acc_s  = !reset && data_sram_req && !data_sram_wr &&
                  !data_busy_s && (rd_state_q == RD_IDLE);
    store_acc_s = !reset && data_sram_req && data_sram_wr && !data_busy_s;
    fetch_acc_s = !reset && inst_sram_req && (rd_state_q == RD_IDLE) &&
                  !load_acc_s;
  end

  // Read FSM next state and AR request capture.
  always_comb begin
    rd_state_d = rd_state_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (load_acc_s) begin
          rd_state_d = RD_AR;
          arid_d     = 4'd1;
          araddr_d   = data_sram_addr;
          arsize_d   = {1'b0, data_sram_size};
        end else if (fetch_acc_s) begin
          rd_state_d = RD_AR;
          arid_d     = 4'd0;
          araddr_d   = inst_sram_addr;
          arsize_d   = {1'b0, inst_sram_size};
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_AR: begin
        if (arready) begin
          rd_state_d = RD_R;
        end else begin
          rd_state_d = RD_AR;
        end
      end
      RD_R: begin
        if (rvalid) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_R;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Read FSM state and AR request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      arid_q     <= 4'd0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
    end else begin
      rd_state_q <= rd_state_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
    end
  end

  // Write FSM next state; AW and W valids drop independently on their own
  // handshake, and the response phase starts once both have gone.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    awsize_d   = awsize_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (store_acc_s) begin
          wr_state_d = WR_AW;
          awaddr_d   = data_sram_addr;
          awsize_d   = {1'b0, data_sram_size};
          wdata_d    = data_sram_wdata;
          wstrb_d    = data_sram_wstrb;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_AW: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          wr_state_d = WR_B;
        end else begin
          wr_state_d = WR_AW;
        end
      end
      WR_B: begin
        if (bvalid) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_B;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
      end
    endcase
  end

  // Write FSM state, AW/W request registers and their valid flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      awaddr_q   <= 32'd0;
      awsize_q   <= 3'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
    end
  end

  // Core-side handshakes. The two data_ok terms cannot coincide because the
  // data port never has a load and a store outstanding together.
  assign inst_sram_addr_ok = fetch_acc_s;
  assign data_sram_addr_ok = load_acc_s | store_acc_s;
  assign inst_sram_data_ok = !reset && rvalid && rready && (rid == 4'd0);
  assign data_sram_data_ok = !reset &&
                             ((rvalid && rready && (rid == 4'd1)) ||
                              (bvalid && bready));
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // AXI request outputs, all from registers.
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (rd_state_q == RD_AR);
  assign rready  = (rd_state_q == RD_R);
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign bready  = (wr_state_q == WR_B);

  // Fixed single-beat, incrementing, normal-access attributes.
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign awid    = 4'd1;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;

  // Inputs the bridge deliberately ignores.
  assign unused_inputs_s = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_axi_bridge.sv
module tb_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Inputs are driven just after a rising edge; outputs are sampled on the
  // falling edge of the same cycle.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0;
    bvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b0;
    adv();
    settle();
    checks++;
    if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshakes: got %b want 0000", {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b00000) begin
      errors++; $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    checks++;
    if ({araddr, awaddr, wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_regs: araddr %h awaddr %h wdata %h want 0", araddr, awaddr, wdata);
    end
    checks++;
    if ({arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot, awid, wid, wlast}
        !== {4'd0, 4'd0, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0, 3'd0, 3'd0, 4'd1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL tieoffs: arlen %h awlen %h arburst %b awburst %b awid %h wid %h wlast %b", arlen, awlen, arburst, awburst, awid, wid, wlast);
    end
    adv();
    idle_inputs();
    reset = 1'b0;
    settle();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, data_sram_addr_ok} !== 6'd0) begin
      errors++; $display("FAIL post_reset_idle: got %b want 000000", {arvalid, awvalid, wvalid, rready, bready, data_sram_addr_ok});
    end
    adv();
  endtask

  task automatic test_fetch();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2; arready = 1'b1;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL fetch_addr_ok: got %b want 1", inst_sram_addr_ok); end
    adv(); inst_sram_req = 1'b0;
    settle();
    checks++;
    if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h1c000000, 3'd2}) begin
      errors++; $display("FAIL fetch_ar: got v%b id%h %h sz%h want v1 id0 1c000000 sz2", arvalid, arid, araddr, arsize);
    end
    adv(); arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c0c;
    settle();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {1'b1, 1'b0, 32'h02800c0c}) begin
      errors++; $display("FAIL fetch_data_ok: got ok%b dok%b rdata %h want ok1 dok0 02800c0c", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
    end
    adv(); rvalid = 1'b0;
    settle();
    checks++;
    if ({inst_sram_data_ok, arvalid, rready} !== 3'b000) begin
      errors++; $display("FAIL fetch_done: got %b want 000", {inst_sram_data_ok, arvalid, rready});
    end
    adv();
  endtask

  task automatic test_arbitration();
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1000; data_sram_size = 2'd2;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000040;
    settle();
    checks++;
    if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL arb_winner: got data%b inst%b want data1 inst0", data_sram_addr_ok, inst_sram_addr_ok);
    end
    adv(); data_sram_req = 1'b0; arready = 1'b1;
    settle();
    checks++;
    if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h1000, 1'b0}) begin
      errors++; $display("FAIL arb_load_ar: got v%b id%h %h iok%b want v1 id1 00001000 iok0", arvalid, arid, araddr, inst_sram_addr_ok);
    end
    adv(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hcafef00d;
    settle();
    checks++;
    if ({data_sram_data_ok, inst_sram_addr_ok, data_sram_rdata} !== {1'b1, 1'b0, 32'hcafef00d}) begin
      errors++; $display("FAIL arb_load_resp: got dok%b iok%b %h want dok1 iok0 cafef00d", data_sram_data_ok, inst_sram_addr_ok, data_sram_rdata);
    end
    adv(); rvalid = 1'b0;
    settle();
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL arb_fetch_after: got %b want 1", inst_sram_addr_ok); end
    adv(); inst_sram_req = 1'b0; arready = 1'b1;
    settle();
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1c000040}) begin
      errors++; $display("FAIL arb_fetch_ar: got v%b id%h %h want v1 id0 1c000040", arvalid, arid, araddr);
    end
    adv(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0;
    settle();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin
      errors++; $display("FAIL arb_fetch_resp: got %b want 10", {inst_sram_data_ok, data_sram_data_ok});
    end
    adv(); rvalid = 1'b0;
  endtask

  task automatic test_store_split();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h2004; data_sram_size = 2'd2;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hdeadbeef;
    settle();
    checks++;
    if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL store_addr_ok: got %b want 1", data_sram_addr_ok); end
    adv(); data_sram_req = 1'b0; data_sram_wr = 1'b0; awready = 1'b1;
    settle();
    checks++;
    if ({awvalid, wvalid, awaddr, awsize, wdata, wstrb} !== {2'b11, 32'h2004, 3'd2, 32'hdeadbeef, 4'b0011}) begin
      errors++; $display("FAIL store_c1: got aw%b w%b %h sz%h %h %b", awvalid, wvalid, awaddr, awsize, wdata, wstrb);
    end
    adv(); awready = 1'b0;
    settle();
    checks++;
    if ({awvalid, wvalid, wdata} !== {2'b01, 32'hdeadbeef}) begin
      errors++; $display("FAIL store_c2: got aw%b w%b %h want aw0 w1 deadbeef", awvalid, wvalid, wdata);
    end
    adv(); wready = 1'b1;
    settle();
    checks++;
    if ({wvalid, wstrb, bready} !== {1'b1, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL store_c3: got w%b %b bready%b want w1 0011 bready0", wvalid, wstrb, bready);
    end
    adv(); wready = 1'b0;
    settle();
    checks++;
    if ({wvalid, bready, data_sram_data_ok} !== 3'b010) begin
      errors++; $display("FAIL store_c4: got %b want 010", {wvalid, bready, data_sram_data_ok});
    end
    adv(); bvalid = 1'b1;
    settle();
    checks++;
    if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL store_data_ok: got %b want 1", data_sram_data_ok); end
    adv(); bvalid = 1'b0;
  endtask

  task automatic test_store_then_load();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h2008;
    data_sram_wstrb = 4'b1111; data_sram_wdata = 32'h13572468;
    settle();
    checks++;
    if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL stl_store_ok: got %b want 1", data_sram_addr_ok); end
    adv(); data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
    adv(); awready = 1'b0; wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h3000;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000080;
    settle();
    checks++;
    if ({data_sram_addr_ok, inst_sram_addr_ok, bready} !== 3'b011) begin
      errors++; $display("FAIL stl_wr_b: got dok%b iok%b bready%b want 0 1 1", data_sram_addr_ok, inst_sram_addr_ok, bready);
    end
    adv(); inst_sram_req = 1'b0; arready = 1'b1;
    settle();
    checks++;
    if ({data_sram_addr_ok, arvalid, arid} !== {2'b01, 4'd0}) begin
      errors++; $display("FAIL stl_fetch_ar: got aok%b v%b id%h want 0 1 0", data_sram_addr_ok, arvalid, arid);
    end
    adv(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0; bvalid = 1'b1;
    settle();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, data_sram_addr_ok} !== 3'b110) begin
      errors++; $display("FAIL stl_resp: got %b want 110", {inst_sram_data_ok, data_sram_data_ok, data_sram_addr_ok});
    end
    adv(); rvalid = 1'b0; bvalid = 1'b0;
    settle();
    checks++;
    if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL stl_load_ok: got %b want 1", data_sram_addr_ok); end
    adv(); data_sram_req = 1'b0; arready = 1'b1;
    settle();
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h3000}) begin
      errors++; $display("FAIL stl_load_ar: got v%b id%h %h want v1 id1 00003000", arvalid, arid, araddr);
    end
    adv(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1;
    settle();
    checks++;
    if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL stl_load_resp: got %b want 1", data_sram_data_ok); end
    adv(); rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h4000;
    settle();
    checks++;
    if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b want 1", data_sram_addr_ok); end
    adv(); data_sram_req = 1'b0; arready = 1'b1;
    adv(); arready = 1'b0; reset = 1'b1;
    adv(); reset = 1'b0; rvalid = 1'b1; rid = 4'd1;
    settle();
    checks++;
    if ({arvalid, rready, data_sram_data_ok, inst_sram_data_ok} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_after: got %b want 0000", {arvalid, rready, data_sram_data_ok, inst_sram_data_ok});
    end
    adv(); rvalid = 1'b0;
    data_sram_req = 1'b1; data_sram_addr = 32'h5000;
    settle();
    checks++;
    if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b want 1", data_sram_addr_ok); end
    adv(); data_sram_req = 1'b0; arready = 1'b1;
    settle();
    checks++;
    if ({arvalid, araddr} !== {1'b1, 32'h5000}) begin
      errors++; $display("FAIL rstmid_new_ar: got v%b %h want v1 00005000", arvalid, araddr);
    end
    adv(); arready = 1'b0; rvalid = 1'b1; rid = 4'd1;
    settle();
    checks++;
    if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL rstmid_new_resp: got %b want 1", data_sram_data_ok); end
    adv(); rvalid = 1'b0;
  endtask

  // Random single transactions with random slave latencies. Expected AXI
  // fields come straight from the request: id from the winning port,
  // address, size zero-extended, strobes/data as issued.
  task automatic test_random(input int n);
    int kind, d1, d2, da, dw, db;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr, rd;
    logic [2:0]  exp_size;
    logic        aw_done, w_done;
    for (int t = 0; t < n; t++) begin
      kind = int'($urandom_range(0, 3));
      inst_sram_addr = $urandom; inst_sram_size = 2'($urandom_range(0, 2));
      data_sram_addr = $urandom; data_sram_size = 2'($urandom_range(0, 2));
      data_sram_wstrb = 4'($urandom); data_sram_wdata = $urandom;
      rd = $urandom;
      if (kind == 2) begin
        data_sram_req = 1'b1; data_sram_wr = 1'b1;
        settle();
        checks++;
        if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin
          errors++; $display("FAIL rnd_store_accept t%0d: got %b want 10", t, {data_sram_addr_ok, inst_sram_addr_ok});
        end
        adv(); data_sram_req = 1'b0; data_sram_wr = 1'b0;
        da = int'($urandom_range(0, 3)); dw = int'($urandom_range(0, 3));
        aw_done = 1'b0; w_done = 1'b0;
        for (int c = 0; c < 8 && !(aw_done && w_done); c++) begin
          awready = (c == da); wready = (c == dw);
          settle();
          checks++;
          if ({awvalid, wvalid} !== {!aw_done, !w_done} ||
              (!aw_done && {awaddr, awsize} !== {data_sram_addr, 1'b0, data_sram_size}) ||
              (!w_done && {wdata, wstrb} !== {data_sram_wdata, data_sram_wstrb})) begin
            errors++; $display("FAIL rnd_store_aw t%0d c%0d: aw%b w%b %h %h %b want aw%b w%b %h %h %b", t, c,
              awvalid, wvalid, awaddr, wdata, wstrb, !aw_done, !w_done, data_sram_addr, data_sram_wdata, data_sram_wstrb);
          end
          adv();
          if (c == da) aw_done = 1'b1;
          if (c == dw) w_done = 1'b1;
        end
        awready = 1'b0; wready = 1'b0;
        db = int'($urandom_range(0, 3));
        for (int k = 0; k <= db; k++) begin
          bvalid = (k == db);
          settle();
          checks++;
          if ({bready, data_sram_data_ok, inst_sram_data_ok} !== {1'b1, k == db, 1'b0}) begin
            errors++; $display("FAIL rnd_store_b t%0d k%0d: got %b want 1%b0", t, k, {bready, data_sram_data_ok, inst_sram_data_ok}, k == db);
          end
          adv();
        end
        bvalid = 1'b0;
      end else begin
        inst_sram_req = (kind != 1);
        data_sram_req = (kind != 0); data_sram_wr = 1'b0;
        exp_id   = (kind == 0) ? 4'd0 : 4'd1;
        exp_addr = (kind == 0) ? inst_sram_addr : data_sram_addr;
        exp_size = (kind == 0) ? {1'b0, inst_sram_size} : {1'b0, data_sram_size};
        settle();
        checks++;
        if ({inst_sram_addr_ok, data_sram_addr_ok} !== {kind == 0, kind != 0}) begin
          errors++; $display("FAIL rnd_read_accept t%0d kind%0d: got %b want %b%b", t, kind, {inst_sram_addr_ok, data_sram_addr_ok}, kind == 0, kind != 0);
        end
        adv(); inst_sram_req = 1'b0; data_sram_req = 1'b0;
        d1 = int'($urandom_range(0, 3));
        for (int k = 0; k <= d1; k++) begin
          arready = (k == d1);
          settle();
          checks++;
          if ({arvalid, arid, araddr, arsize} !== {1'b1, exp_id, exp_addr, exp_size}) begin
            errors++; $display("FAIL rnd_ar t%0d k%0d: got v%b id%h %h sz%h want v1 id%h %h sz%h", t, k, arvalid, arid, araddr, arsize, exp_id, exp_addr, exp_size);
          end
          adv();
        end
        arready = 1'b0;
        d2 = int'($urandom_range(0, 3));
        for (int k = 0; k <= d2; k++) begin
          rvalid = (k == d2); rid = exp_id; rdata = rd;
          settle();
          checks++;
          if ({rready, inst_sram_data_ok, data_sram_data_ok} !== {1'b1, (k == d2) && (exp_id == 4'd0), (k == d2) && (exp_id == 4'd1)} ||
              ((k == d2) && ((exp_id == 4'd0 ? inst_sram_rdata : data_sram_rdata) !== rd))) begin
            errors++; $display("FAIL rnd_r t%0d k%0d: rready%b iok%b dok%b rdata %h want id%h rdata %h", t, k, rready, inst_sram_data_ok, data_sram_data_ok, rdata, exp_id, rd);
          end
          adv();
        end
        rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    adv(); adv();
    test_reset();
    test_fetch();
    test_arbitration();
    test_store_split();
    test_store_then_load();
    test_reset_mid();
    test_random(80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
